pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 40 ++++
 rtl/pwm_tick_gen.sv | 34 +++
 rtl/pwm_ramp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pwm_pkg;

  localparam int DUTY_W = 16;
  localparam int CH_W   = 4;
  localparam int MAX_CH = 1 << CH_W;

  // Layout of both the target-update word and the outgoing duty word.
  typedef struct packed {
    logic [3:0]        rsvd;
    logic [CH_W-1:0]   ch;
    logic [DUTY_W-1:0] duty;
  } pwm_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND
  } ramp_state_e;

  // One ramp step from cur toward tgt, clamped so it lands exactly on tgt
  // instead of overshooting; the subtraction order keeps it wrap-free.
  function automatic logic [DUTY_W-1:0] ramp_next(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] diff;
    if (tgt > cur) begin
      diff      = tgt - cur;
      ramp_next = cur + ((diff < step) ? diff : step);
    end else begin
      diff      = cur - tgt;
      ramp_next = cur - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Ramp tick generator: free-running 0..TICK_DIV-1 counter, one-cycle tick at the top count.
// Latency: first tick TICK_DIV-1 cycles after reset release, then every TICK_DIV cycles.
// Backpressure: none; ticks are never held, the consumer must latch them.
module pwm_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero after the last count of the period.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST) & ~rst;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp controller: slews each channel's PWM duty toward its requested target, at most STEP per tick.
// Latency: a sweep starts the cycle after a tick; one SCAN cycle per channel, one SEND per changed channel.
// Backpressure: s_axis always ready outside reset; m_axis word held until accepted, ticks meanwhile fold into one pending sweep.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int TICK_DIV = 100,
  parameter int STEP     = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     s_axis_tvalid,
  output logic     s_axis_tready,
  input  pwm_cfg_t s_axis_tdata,
  output logic     m_axis_tvalid,
  input  logic     m_axis_tready,
  output pwm_cfg_t m_axis_tdata,
  output logic     busy
);

  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]     NUM_CH_W = (CH_W + 1)'(NUM_CH);
  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

  logic tick;

  ramp_state_e       state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              m_vld_q, m_vld_d;
  pwm_cfg_t          m_dat_q, m_dat_d;
  logic [DUTY_W-1:0] cur_q [MAX_CH];
  logic [DUTY_W-1:0] cur_d [MAX_CH];
  logic [DUTY_W-1:0] tgt_q [MAX_CH];
  logic [DUTY_W-1:0] tgt_d [MAX_CH];

  logic              wr_ok;
  logic              last_ch;
  logic              busy_any;
  logic [DUTY_W-1:0] cur_sel;
  logic [DUTY_W-1:0] tgt_sel;
  logic [3:0]        unused_rsvd;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Reserved bits of the target word carry no meaning here.
  assign unused_rsvd = s_axis_tdata.rsvd;

  assign s_axis_tready = ~rst;
  assign wr_ok   = s_axis_tvalid & s_axis_tready & ({1'b0, s_axis_tdata.ch} < NUM_CH_W);
  assign last_ch = (idx_q == LAST_CH);
  assign cur_sel = cur_q[idx_q];
  assign tgt_sel = tgt_q[idx_q];

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;

  // Any active channel still away from its target keeps busy high.
  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_q[i] != tgt_q[i]) begin
        busy_any = 1'b1;
      end
    end
  end

  assign busy = busy_any & ~rst;

  // Sweep sequencer: target capture, channel scan, duty word issue and pending-tick folding.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    m_vld_d   = m_vld_q;
    m_dat_d   = m_dat_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;

    // Target writes land in every state; an in-flight word keeps its old value.
    if (wr_ok) begin
      tgt_d[s_axis_tdata.ch] = s_axis_tdata.duty;
    end

    case (state_q)
      ST_IDLE: begin
        // A coincident tick and pending request still start only one sweep.
        if (tick || pending_q) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end

      ST_SCAN: begin
        if (tick) begin
          pending_d = 1'b1;
        end
        if (cur_sel != tgt_sel) begin
          state_d      = ST_SEND;
          m_vld_d      = 1'b1;
          m_dat_d.rsvd = '0;
          m_dat_d.ch   = idx_q;
          m_dat_d.duty = ramp_next(cur_sel, tgt_sel, STEP_V);
        end else if (last_ch) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_SEND: begin
        if (tick) begin
          pending_d = 1'b1;
        end
        if (m_axis_tready) begin
          cur_d[idx_q] = m_dat_q.duty;
          m_vld_d      = 1'b0;
          if (last_ch) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, channel registers and the registered m_axis word, all synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      m_vld_q   <= 1'b0;
      m_dat_q   <= '0;
      cur_q     <= '{default: '0};
      tgt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      m_vld_q   <= m_vld_d;
      m_dat_q   <= m_dat_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (16 ch / STEP 1 and 8 ch / STEP 4) share one stimulus stream.
// Sweep-level reference model predicts the word list of every tick period.
// Directed steps cover reset, ramp up/down, ordering, out-of-range channel, stall/pending and reset in SEND.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_vld;
  logic [23:0] s_dat;
  logic        m_rdy;
  logic        s_rdy_a, s_rdy_b;
  logic        m_vld_a, m_vld_b;
  logic [23:0] m_dat_a, m_dat_b;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  logic [23:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$], last_a[$], last_b[$], wq[$];

  int mcur [2][16];
  int mtgt [2][16];
  int mstep [2] = '{1, 4};
  int mnch  [2] = '{16, 8};

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.NUM_CH(16), .TICK_DIV(100), .STEP(1)) u_dut_a (
    .clk(clk), .rst(rst), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy_a), .s_axis_tdata(s_dat),
    .m_axis_tvalid(m_vld_a), .m_axis_tready(m_rdy), .m_axis_tdata(m_dat_a), .busy(busy_a));

  pwm_ramp_ctrl #(.NUM_CH(8), .TICK_DIV(100), .STEP(4)) u_dut_b (
    .clk(clk), .rst(rst), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy_b), .s_axis_tdata(s_dat),
    .m_axis_tvalid(m_vld_b), .m_axis_tready(m_rdy), .m_axis_tdata(m_dat_b), .busy(busy_b));

  // Inputs change 1 time unit after posedge, so at negedge a valid&ready pair is a handshake at the next edge.
  always @(negedge clk) begin
    if (!rst && m_vld_a && m_rdy) obs_a.push_back(m_dat_a);
    if (!rst && m_vld_b && m_rdy) obs_b.push_back(m_dat_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_until(input int n);
    while (t < n) step();
  endtask

  function automatic bit mbusy(input int k);
    bit b = 1'b0;
    for (int i = 0; i < mnch[k]; i++) if (mcur[k][i] != mtgt[k][i]) b = 1'b1;
    return b;
  endfunction

  // One tick's sweep: every channel away from target moves by min(step, distance), ascending order.
  task automatic sweep_model(input int k);
    int d, s, nxt;
    for (int ch = 0; ch < mnch[k]; ch++) begin
      if (mcur[k][ch] != mtgt[k][ch]) begin
        d   = (mtgt[k][ch] > mcur[k][ch]) ? mtgt[k][ch] - mcur[k][ch] : mcur[k][ch] - mtgt[k][ch];
        s   = (d < mstep[k]) ? d : mstep[k];
        nxt = (mtgt[k][ch] > mcur[k][ch]) ? mcur[k][ch] + s : mcur[k][ch] - s;
        if (k == 0) exp_a.push_back(24'((ch << 16) | nxt));
        else        exp_b.push_back(24'((ch << 16) | nxt));
        mcur[k][ch] = nxt;
      end
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [15:0] duty);
    s_vld = 1'b1;
    s_dat = {4'($urandom_range(0, 15)), ch, duty};
    check("s_rdy", {30'd0, s_rdy_a, s_rdy_b}, 32'd3);
    for (int k = 0; k < 2; k++) if (int'(ch) < mnch[k]) mtgt[k][ch] = int'(duty);
    step();
    s_vld = 1'b0;
  endtask

  task automatic cmp_q(input string tag, input logic [23:0] o[$], input logic [23:0] e[$]);
    check({tag, "_cnt"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++)
      check($sformatf("%s_w%0d", tag, i), o[i], e[i]);
  endtask

  task automatic compare();
    cmp_q("swp_a", obs_a, exp_a);
    cmp_q("swp_b", obs_b, exp_b);
    check("busy_a", busy_a, mbusy(0));
    check("busy_b", busy_b, mbusy(1));
    last_a = obs_a;
    last_b = obs_b;
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  // One tick period aligned to counter value 0: writes mid-period, check previous sweep, then predict the next.
  task automatic period();
    int base = t;
    logic [23:0] w;
    wait_until(base + 40);
    while (wq.size() > 0) begin
      w = wq.pop_front();
      wr(w[19:16], w[15:0]);
    end
    wait_until(base + 95);
    compare();
    wait_until(base + 99);
    sweep_model(0);
    sweep_model(1);
    wait_until(base + 100);
  endtask

  // Reset for one cycle; all observable state must read as zero while rst is still high.
  task automatic do_reset();
    rst = 1'b1;
    step();
    check("rst_s_rdy", {s_rdy_a, s_rdy_b}, 0);
    check("rst_m_vld", {m_vld_a, m_vld_b}, 0);
    check("rst_m_dat_a", m_dat_a, 0);
    check("rst_m_dat_b", m_dat_b, 0);
    check("rst_busy", {busy_a, busy_b}, 0);
    rst = 1'b0;
    t = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        mcur[k][i] = 0;
        mtgt[k][i] = 0;
      end
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    logic [23:0] held;
    bit          ok;
    int          n;
    rst = 1'b1; s_vld = 1'b0; s_dat = '0; m_rdy = 1'b1;

    do_reset();

    // ch3 -> 5: A emits 1..5 one per tick, B (step 4) emits 4 then 5.
    wq.push_back({4'h0, 4'd3, 16'd5});
    period();
    period();
    check("r034_first_a", last_a[0], 24'h030001);
    check("r034_first_b", last_b[0], 24'h030004);
    repeat (4) period();
    check("r034_busy_a_low", busy_a, 0);
    period();
    check("r034_no_more_a", last_a.size(), 0);

    // ch0 ramps to 10, then down to 3: B emits 4,8,10 then 6,3 with no undershoot.
    wq.push_back({4'h0, 4'd0, 16'd10});
    period();
    period();
    period();
    wq.push_back({4'h0, 4'd0, 16'd3});
    period();
    period();
    check("r035_down1_b", last_b[0], 24'h000006);
    period();
    check("r035_down2_b", last_b[0], 24'h000003);
    period();
    check("r035_settled_b", last_b.size(), 0);

    // Channel 12 is out of range for the 8-channel instance.
    wq.push_back({4'h0, 4'd12, 16'd100});
    period();
    check("r038_busy_b", busy_b, 0);

    // ch1 and ch15 in the same window: every sweep lists ch1 before ch15.
    wq.push_back({4'h0, 4'd1, 16'd2});
    wq.push_back({4'h0, 4'd15, 16'd2});
    period();
    check("r038_no_word_b", last_b.size(), 0);
    period();
    check("r036_first_ch1", last_a[0], 24'h010001);
    check("r036_last_ch15", last_a[last_a.size() - 1], 24'h0f0001);
    period();

    // Randomized targets and channels against the sweep model.
    repeat (12) begin
      n = $urandom_range(1, 4);
      repeat (n)
        wq.push_back({4'h0, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 20))});
      period();
    end
    period();

    // Stall the word for 250 cycles across two ticks: exactly one catch-up sweep afterwards.
    do_reset();
    wait_until(40);
    m_rdy = 1'b0;
    wr(4'd5, 16'd3);
    wait_until(110);
    check("r037_vld_a", m_vld_a, 1);
    check("r037_dat_a", m_dat_a, 24'h050001);
    check("r037_dat_b", m_dat_b, 24'h050003);
    held = m_dat_a;
    ok = 1'b1;
    repeat (250) begin
      step();
      if (m_vld_a !== 1'b1 || m_dat_a !== held) ok = 1'b0;
    end
    check("r037_hold_a", ok, 1);
    m_rdy = 1'b1;
    wait_until(395);
    check("r037_cnt_a", obs_a.size(), 2);
    check("r037_w0_a", obs_a[0], 24'h050001);
    check("r037_w1_a", obs_a[1], 24'h050002);
    check("r037_cnt_b", obs_b.size(), 1);
    check("r037_w0_b", obs_b[0], 24'h050003);
    wait_until(440);
    check("r037_tick_cnt_a", obs_a.size(), 3);
    check("r037_tick_w_a", obs_a[2], 24'h050003);
    check("r037_busy_a", busy_a, 0);

    // Reset pulse while a word is stalled in SEND drops it and clears all channels.
    wait_until(445);
    m_rdy = 1'b0;
    wr(4'd7, 16'd9);
    wait_until(512);
    check("r039_pre_vld_a", m_vld_a, 1);
    do_reset();
    m_rdy = 1'b1;
    wait_until(250);
    check("r039_quiet_a", obs_a.size(), 0);
    check("r039_quiet_b", obs_b.size(), 0);
    check("r039_busy", {busy_a, busy_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
